// File: rtl/mskaes_32bits_key_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_32bits_key_sched_ctrl_if
// Brief    : Handshake and control bundle of the masked AES key-schedule FSM.
// Revision : 1.0
// ============================================================================
interface mskaes_32bits_key_sched_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       ak_valid;
   logic       ak_ready;
   logic [1:0] ak_col;
   logic       ak_last;
   logic [3:0] rnd;
   logic       sb_grant;
   logic       sb_valid;
   logic       key_init;
   logic       key_enable;
   logic       key_loop;
   logic       key_add_from_sb;
   logic       key_rcon_rst;
   logic       key_rcon_update;

   modport slave (
      input  start, ak_ready, sb_grant,
      output busy, done, ak_valid, ak_col, ak_last, rnd, sb_valid,
             key_init, key_enable, key_loop, key_add_from_sb,
             key_rcon_rst, key_rcon_update
   );

   modport master (
      output start, ak_ready, sb_grant,
      input  busy, done, ak_valid, ak_col, ak_last, rnd, sb_valid,
             key_init, key_enable, key_loop, key_add_from_sb,
             key_rcon_rst, key_rcon_update
   );
endinterface
`default_nettype wire

// File: rtl/mskaes_32bits_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_32bits_key_sched_ctrl
// Brief    : Control FSM of the 32-bit column-serial masked AES-128 key schedule.
// Revision : 1.0
// ============================================================================
module mskaes_32bits_key_sched_ctrl #(
   parameter int SBOX_LAT = 4,
   parameter int NROUNDS  = 10
) (
   input  logic clk,
   input  logic rst,
   mskaes_32bits_key_sched_ctrl_if.slave ks
);
   localparam int              c_WAIT_W    = (SBOX_LAT > 2) ? $clog2(SBOX_LAT) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((SBOX_LAT > 1) ? SBOX_LAT - 2 : 0);
   localparam logic [3:0]      c_LAST_RND  = 4'(NROUNDS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_AK      = 3'd2,
      S_SB_FEED = 3'd3,
      S_SB_WAIT = 3'd4,
      S_UPD     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t              r_state;
   logic [1:0]          r_beat;
   logic [c_WAIT_W-1:0] r_wait;
   logic [3:0]          r_rnd;

   // r_beat counts AK columns and UPD beats; it wraps to 0 at the end of each.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_beat  <= 2'd0;
         r_wait  <= '0;
         r_rnd   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ks.start) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_rnd   <= 4'd0;
               r_beat  <= 2'd0;
               r_state <= S_AK;
            end
            S_AK: begin
               if (ks.ak_ready) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == 2'd3)
                     r_state <= (r_rnd == c_LAST_RND) ? S_DONE : S_SB_FEED;
               end
            end
            S_SB_FEED: begin
               if (ks.sb_grant) begin
                  r_wait  <= '0;
                  r_state <= (SBOX_LAT > 1) ? S_SB_WAIT : S_UPD;
               end
            end
            S_SB_WAIT: begin
               r_wait <= r_wait + 1'b1;
               if (r_wait == c_WAIT_LAST) r_state <= S_UPD;
            end
            S_UPD: begin
               r_beat <= r_beat + 2'd1;
               if (r_beat == 2'd3) begin
                  r_rnd   <= r_rnd + 4'd1;
                  r_state <= S_AK;
               end
            end
            S_DONE: begin
               r_rnd   <= 4'd0;
               r_beat  <= 2'd0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Moore decodes; only key_enable (AK) and sb_valid look at live inputs.
   always_comb begin
      ks.busy            = (r_state != S_IDLE);
      ks.done            = (r_state == S_DONE);
      ks.ak_valid        = (r_state == S_AK);
      ks.ak_col          = (r_state == S_AK) ? r_beat : 2'd0;
      ks.ak_last         = (r_state == S_AK) && (r_beat == 2'd3) && (r_rnd == c_LAST_RND);
      ks.rnd             = r_rnd;
      ks.sb_valid        = (r_state == S_SB_FEED) && ks.sb_grant;
      ks.key_init        = (r_state == S_LOAD);
      ks.key_rcon_rst    = (r_state == S_LOAD);
      ks.key_loop        = (r_state == S_AK);
      ks.key_add_from_sb = (r_state == S_UPD) && (r_beat == 2'd0);
      ks.key_rcon_update = (r_state == S_UPD) && (r_beat == 2'd0);
      ks.key_enable      = !rst && ((r_state == S_LOAD) || (r_state == S_UPD) ||
                                    ((r_state == S_AK) && ks.ak_ready));
   end
endmodule
`default_nettype wire

// File: tb/tb_mskaes_32bits_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mskaes_32bits_key_sched_ctrl
// Brief    : Schedule-list reference model plus unmasked key datapath model.
// Revision : 1.0
// ============================================================================
module tb_mskaes_32bits_key_sched_ctrl;
   localparam int SBOX_LAT = 4;
   localparam int NR       = 10;
   localparam int K_LOAD = 1, K_AK = 2, K_FEED = 3, K_WAIT = 4, K_UPD = 5, K_DONE = 6;
   localparam logic [127:0] c_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

   typedef struct {
      int kind;
      int rnd;
      int idx;
   } slot_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mskaes_32bits_key_sched_ctrl_if ks();

   mskaes_32bits_key_sched_ctrl #(.SBOX_LAT(SBOX_LAT), .NROUNDS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .ks  (ks)
   );

   always #5 clk = ~clk;

   int    vectors = 0;
   int    miscompares = 0;
   int    rel = 0;
   int    tick = 0;
   slot_t sched[$];

   int done_cnt, done_cyc, last_cyc, sb_cnt, sb_first, upd_cnt, upd_off, beat_cnt, idle_cyc;
   int last_sb = -100;
   logic [127:0] kw;
   logic [31:0]  sbw, last_nw, akw[44];
   logic [7:0]   rcon;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s rel=%0d got=%0h want=%0h", name, rel, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      for (int i = 1; i < 256; i++)
         if (gmul(v, 8'(i)) == 8'h01) inv = 8'(i);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic void build_run();
      sched.push_back(slot_t'{K_LOAD, 0, 0});
      for (int r = 0; r <= NR; r++) begin
         for (int c = 0; c < 4; c++) sched.push_back(slot_t'{K_AK, r, c});
         if (r < NR) begin
            sched.push_back(slot_t'{K_FEED, r, 0});
            for (int w = 0; w < SBOX_LAT - 1; w++) sched.push_back(slot_t'{K_WAIT, r, w});
            for (int b = 0; b < 4; b++) sched.push_back(slot_t'{K_UPD, r, b});
         end
      end
      sched.push_back(slot_t'{K_DONE, NR, 0});
   endfunction

   // Per-cycle compare, run statistics, key datapath model, then model advance.
   always @(negedge clk) begin
      slot_t cur;
      bit    act;
      int    ix;
      logic [31:0] nw, rw;
      tick++;
      act = (sched.size() > 0);
      cur = act ? sched[0] : slot_t'{0, 0, 0};

      check("busy",     int'(ks.busy),     int'(act));
      check("done",     int'(ks.done),     int'(cur.kind == K_DONE));
      check("ak_valid", int'(ks.ak_valid), int'(cur.kind == K_AK));
      check("ak_col",   int'(ks.ak_col),   (cur.kind == K_AK) ? cur.idx : 0);
      check("ak_last",  int'(ks.ak_last),  int'(cur.kind == K_AK && cur.rnd == NR && cur.idx == 3));
      check("rnd",      int'(ks.rnd),      act ? cur.rnd : 0);
      check("sb_valid", int'(ks.sb_valid), int'(cur.kind == K_FEED && ks.sb_grant));
      check("key_init", int'(ks.key_init), int'(cur.kind == K_LOAD));
      check("rcon_rst", int'(ks.key_rcon_rst), int'(cur.kind == K_LOAD));
      check("key_loop", int'(ks.key_loop), int'(cur.kind == K_AK));
      check("add_sb",   int'(ks.key_add_from_sb), int'(cur.kind == K_UPD && cur.idx == 0));
      check("rcon_upd", int'(ks.key_rcon_update), int'(cur.kind == K_UPD && cur.idx == 0));
      check("key_en",   int'(ks.key_enable), int'(!rst && (cur.kind == K_LOAD || cur.kind == K_UPD ||
                                                           (cur.kind == K_AK && ks.ak_ready))));

      if (ks.done) begin done_cnt++; done_cyc = rel; end
      if (ks.ak_last) last_cyc = rel;
      if (ks.sb_valid) begin
         sb_cnt++;
         if (sb_first < 0) sb_first = rel;
         last_sb = tick;
      end
      if (ks.key_add_from_sb) begin
         upd_cnt++;
         if (rel % 12 != 10) upd_off++;
         check("sb_align", tick - last_sb, SBOX_LAT);
      end
      if (ks.ak_valid && ks.ak_ready) beat_cnt++;
      if (!ks.busy && idle_cyc < 0 && done_cnt > 0) idle_cyc = rel;

      if (ks.key_enable) begin
         if (ks.key_init) kw = c_KEY;
         else if (ks.key_loop) begin
            ix = int'(ks.rnd) * 4 + int'(ks.ak_col);
            if (ks.ak_valid && ix < 44) akw[ix] = kw[127:96];
            kw = {kw[95:0], kw[127:96]};
         end else begin
            nw = kw[127:96] ^ (ks.key_add_from_sb ? (sbw ^ {rcon, 24'h0}) : last_nw);
            last_nw = nw;
            kw = {kw[95:0], nw};
         end
      end
      if (ks.key_rcon_rst) rcon = 8'h01;
      else if (ks.key_rcon_update) rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      if (ks.sb_valid) begin
         rw  = {kw[23:0], kw[31:24]};
         sbw = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
      end

      if (rst) sched.delete();
      else if (!act) begin
         if (ks.start) build_run();
      end else if (!((cur.kind == K_AK && !ks.ak_ready) || (cur.kind == K_FEED && !ks.sb_grant)))
         void'(sched.pop_front());
   end

   task automatic clear_stats();
      done_cnt = 0; done_cyc = -1; last_cyc = -1; sb_cnt = 0; sb_first = -1;
      upd_cnt = 0; upd_off = 0; beat_cnt = 0; idle_cyc = -1;
      for (int i = 0; i < 44; i++) akw[i] = 32'h0;
      rel = 0;
   endtask

   task automatic step(input bit s, input bit r, input bit g, input bit rs);
      ks.start = s; ks.ak_ready = r; ks.sb_grant = g; rst = rs;
      @(posedge clk);
      #1;
      rel++;
   endtask

   task automatic scenario(input int rdy_at, input int rdy_len, input int gnt_at, input int gnt_len,
                           input int st_a, input int st_b, input int rst_at, input int n);
      clear_stats();
      for (int c = 0; c < n; c++)
         step(c == 0 || c == st_a || c == st_b,
              !(c >= rdy_at && c < rdy_at + rdy_len),
              !(c >= gnt_at && c < gnt_at + gnt_len), c == rst_at);
   endtask

   task automatic check_keys();
      logic [31:0] exp_w[12] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                                 32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605,
                                 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
      int idx[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 40, 41, 42, 43};
      for (int i = 0; i < 12; i++) check("rkey_word", int'(akw[idx[i]]), int'(exp_w[i]));
   endtask

   initial begin
      ks.start = 1'b0; ks.ak_ready = 1'b1; ks.sb_grant = 1'b1;
      clear_stats();
      // reset held, then quiet idle
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
      check("idle_done_cnt", done_cnt, 0);

      // uninterrupted run
      scenario(-1, 0, -1, 0, -1, -1, -1, 135);
      check("full_done_cyc", done_cyc, 126);
      check("full_last_cyc", last_cyc, 125);
      check("full_sb_cnt", sb_cnt, 10);
      check("full_sb_first", sb_first, 6);
      check("full_beats", beat_cnt, 44);
      check("full_upd_cnt", upd_cnt, 10);
      check("full_upd_off", upd_off, 0);
      check("full_idle_cyc", idle_cyc, 127);
      check_keys();

      // AK backpressure at round 5 column 2
      scenario(64, 3, -1, 0, -1, -1, -1, 140);
      check("bp_done_cyc", done_cyc, 129);
      check("bp_beats", beat_cnt, 44);
      check_keys();

      // Sbox grant withheld at the round-3 feed
      scenario(-1, 0, 42, 5, -1, -1, -1, 140);
      check("arb_done_cyc", done_cyc, 131);
      check("arb_sb_cnt", sb_cnt, 10);
      check_keys();

      // reset during UPD beat 1 of round 4, then a fresh run
      scenario(-1, 0, -1, 0, -1, -1, 59, 70);
      check("rst_done_cnt", done_cnt, 0);
      check("rst_busy", int'(ks.busy), 0);
      scenario(-1, 0, -1, 0, -1, -1, -1, 135);
      check("rerun_done_cyc", done_cyc, 126);
      check_keys();

      // start pulses while busy are ignored
      scenario(-1, 0, -1, 0, 26, 126, -1, 140);
      check("sib_done_cnt", done_cnt, 1);
      check("sib_done_cyc", done_cyc, 126);
      check("sib_idle_cyc", idle_cyc, 127);

      // randomized handshakes, starts and occasional resets
      clear_stats();
      for (int c = 0; c < 3000; c++)
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 399) == 0);
      for (int c = 0; c < 3; c++) step(0, 1, 1, 1);
      step(0, 1, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
